// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-way select stage.
// The optional illegal-select counter is enabled with the MUX_ERR_COUNT_EN macro.
package mux_pkg;

  // Width of the illegal-select counter.
  localparam int MUX_ERR_CNT_W = 16;

  // Default datapath width (MIPS word).
  localparam int MUX_DEF_WIDTH = 32;

  // Stored beat: selected data plus the illegal-select flag.
  // The generic skid payload uses the same {data, sel_err} packing.
  typedef struct packed {
    logic [MUX_DEF_WIDTH-1:0] data;
    logic                     sel_err;
  } mux_beat_t;

  // Buffer occupancy, encoded as {head_valid, skid_valid}.
  // Encoding 2'b01 (skid without head) is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } buf_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Handshake: a beat transfers on an edge where valid & ready are both high;
// valid may not depend on ready, and once valid is raised the payload is
// held until the transfer. in_ready is a plain register (= skid empty), so
// there is no combinational path from out_ready to in_ready.
module skid_buf2
  import mux_pkg::*;
#(
  parameter int PW = 33
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    dbg_state
);

  buf_state_e    r_state;
  buf_state_e    w_state_nxt;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_skid;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_skid_nxt;
  logic          r_in_ready;
  logic          w_push;
  logic          w_pop;

  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = (r_state != ST_EMPTY) & out_ready;
  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_payload = r_head;
  assign dbg_state   = r_state;

  // Next-state and entry moves; flush overrides all traffic but keeps head data.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_head_nxt  = in_payload;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_pop) begin
          if (w_push) begin
            w_head_nxt = in_payload;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else if (w_push) begin
          w_skid_nxt  = in_payload;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the pop side can move.
        if (w_pop) begin
          w_head_nxt  = r_skid;
          w_state_nxt = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_head_nxt  = r_head;
      w_skid_nxt  = r_skid;
    end
  end

  // State and storage registers; in_ready tracks "skid will be empty".
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_head     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_head     <= w_head_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// N-way WIDTH-bit selector with registered, flow-controlled output.
// Out-of-range selects produce data 0 with out_sel_err set.
// Optional feature: define MUX_ERR_COUNT_EN to add the saturating err_count port.
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 3,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N*WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel_err,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef MUX_ERR_COUNT_EN
  output logic [MUX_ERR_CNT_W-1:0] err_count,
`endif
  output logic [1:0]               dbg_state
);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic [WIDTH:0]   w_in_payload;
  logic [WIDTH:0]   w_out_payload;
  logic             w_in_ready;

  // Select the addressed input; an index with no matching input flags an error.
  always_comb begin
    w_sel_data = '0;
    w_sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (int'(in_sel) == k) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
        w_sel_err  = 1'b0;
      end
    end
  end

  assign w_in_payload = {w_sel_data, w_sel_err};

  skid_buf2 #(
    .PW (WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_payload  (w_in_payload),
    .in_valid    (in_valid),
    .in_ready    (w_in_ready),
    .out_payload (w_out_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state   (dbg_state)
  );

  assign in_ready    = w_in_ready;
  assign out_data    = w_out_payload[WIDTH:1];
  assign out_sel_err = w_out_payload[0];

`ifdef MUX_ERR_COUNT_EN
  logic [MUX_ERR_CNT_W-1:0] r_err_count;

  // Count every accepted illegal beat (flushed ones too), saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (in_valid && w_in_ready && w_sel_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + {{(MUX_ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Self-checking bench for mux_pipe_stage (N=3, WIDTH=32).
// Build with MUX_ERR_COUNT_EN defined to also exercise err_count.
module tb_mux_pipe_stage;

  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int SEL_W = 2;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic               out_sel_err;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         dbg_state;
`ifdef MUX_ERR_COUNT_EN
  logic [15:0]        err_count;
`endif

  always #5 clk = ~clk;

  mux_pipe_stage #(.WIDTH(WIDTH), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_data    (out_data),
    .out_sel_err (out_sel_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef MUX_ERR_COUNT_EN
    .err_count   (err_count),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0] exp_q[$];      // {sel_err, data}, oldest first
  logic [15:0]    exp_err_cnt;
  int             n_vec;
  int             n_err;
  bit             mon_en;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: legal select picks that input, otherwise zero with error.
  function automatic logic [WIDTH:0] ref_beat(input logic [N*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] words [N];
    for (int k = 0; k < N; k++) words[k] = d[k*WIDTH +: WIDTH];
    if (int'(s) < N) return {1'b0, words[int'(s)]};
    return {1'b1, {WIDTH{1'b0}}};
  endfunction

  // ---------------- issue side: push expected beats ----------------
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
      exp_err_cnt = 16'd0;
    end else if (mon_en) begin
      if (in_valid && in_ready && ref_beat(in_data, in_sel)[WIDTH] &&
          exp_err_cnt != 16'hFFFF)
        exp_err_cnt = exp_err_cnt + 16'd1;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(ref_beat(in_data, in_sel));
    end
  end

  // ---------------- monitor: compare and pop ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      sz = exp_q.size();
      check("out_valid", {63'd0, out_valid}, {63'd0, sz > 0});
      check("in_ready", {63'd0, in_ready}, {63'd0, sz < 2});
      check("state_01", {63'd0, dbg_state == 2'b01}, 64'd0);
      check("occupancy", {62'd0, dbg_state}, {62'd0, sz > 0, sz > 1});
      if (sz > 0 && out_valid) begin
        check("out_data", {32'd0, out_data}, {32'd0, exp_q[0][WIDTH-1:0]});
        check("out_sel_err", {63'd0, out_sel_err}, {63'd0, exp_q[0][WIDTH]});
      end
`ifdef MUX_ERR_COUNT_EN
      check("err_count", {48'd0, err_count}, {48'd0, exp_err_cnt});
`endif
      if (sz > 0 && out_ready && !flush && !reset) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a beat until the stage takes it, bounded.
  task automatic send_hold(input logic [SEL_W-1:0] s, input int bound);
    bit acc;
    acc = 1'b0;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    check("send_accepted", {63'd0, acc}, 64'd1);
  endtask

  logic [N*WIDTH-1:0] base_data;

  // ---------------- stimulus ----------------
  initial begin
    n_vec       = 0;
    n_err       = 0;
    mon_en      = 1'b0;
    exp_err_cnt = 16'd0;
    base_data   = {32'h33, 32'h22, 32'h11};
    reset       = 1'b1;
    in_data     = base_data;
    in_sel      = '0;
    in_valid    = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    repeat (3) tick();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset then idle.
    @(negedge clk);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_sel_err", {63'd0, out_sel_err}, 64'd0);
    tick();

    // Single legal beat, sel=2.
    out_ready = 1'b1;
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Backpressure: two accepted, third held until space frees.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    in_sel = 2'd0;
    repeat (3) tick();
    out_ready = 1'b1;
    send_hold(2'd0, 10);
    repeat (4) tick();

    // Illegal select.
    in_sel   = 2'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Flush with skid full and a beat offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    tick();
    in_sel = 2'd2;
    tick();
    in_sel = 2'd0;
    flush  = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    // Flush with one held beat while a beat is actually accepted.
    in_valid = 1'b1;
    in_sel   = 2'd1;
    tick();
    in_sel = 2'd2;
    flush  = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Random streaming with random backpressure and rare flushes.
    for (int i = 0; i < 1600; i++) begin
      in_data   = {$urandom(), $urandom(), $urandom()};
      in_sel    = SEL_W'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset mid-transfer discards held beats.
    in_valid = 1'b1;
    in_sel   = 2'd3;
    repeat (2) tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

`ifdef MUX_ERR_COUNT_EN
    // Saturate the illegal-select counter.
    in_sel   = 2'd3;
    in_valid = 1'b1;
    repeat (65600) tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("err_count_sat", {48'd0, err_count}, 64'h0000_0000_0000_FFFF);
    tick();
`endif

    repeat (3) tick();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe_stage.md
Name: mux_pipe_stage

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered output, for the pipelined MIPS datapath (forwarding / writeback select).
- Adds valid/ready flow control, a 2-entry skid buffer so in_ready is a pure register, synchronous flush, and illegal-select detection.
- Sits between a producer stage (e.g. EX operand sources) and a consumer stage (e.g. MEM), and replaces the single-cycle select-sensitive muxes in pipelined paths.

Parameters:
- WIDTH, 32, data width per input.
- N, 3, number of inputs; legal range N >= 2.
- SEL_W, $clog2(N), select width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select index.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  stage can accept a beat; registered.
- flush  in  1  synchronous discard of all held beats.
- out_data  out  WIDTH  selected data of the head beat.
- out_sel_err  out  1  head beat had in_sel >= N.
- out_valid  out  1  head beat valid.
- out_ready  in  1  consumer accepts the head beat.
- err_count  out  16  illegal-select counter; present only with MUX_ERR_COUNT_EN.

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, out_data=0, out_sel_err=0, in_ready=1, skid empty, err_count=0.
- Accept: in_valid & in_ready at an edge. Push: captured. Pop: out_valid & out_ready at an edge.
- Captured beat value: data = in_data[in_sel] when in_sel < N; otherwise data = 0 and err bit = 1.
- Storage: two entries, head (drives out_*) and skid. Beats leave in strict arrival order.
- Latency: an accepted beat is on out_* the next cycle when head is empty or popping that cycle.
- Push into empty head, or into a popping head with skid empty: beat goes to head.
- Push while head is held (valid & !out_ready): beat goes to skid. in_ready falls at the next edge.
- Pop with skid full: skid moves to head, skid clears, in_ready=1 at the next edge.
- Pop and push in the same cycle with skid empty: head loads the new beat. Throughput is 1 beat/cycle.
- Full: in_ready=0 means the producer must hold. The stage never overwrites or drops an accepted beat except on flush.
- in_ready = !skid_valid, registered. No combinational path from out_ready to in_ready.
- Flush: at the edge, out_valid=0, skid cleared, in_ready=1. out_data holds its last value.
- Flush priority: flush wins over a push and a pop in the same cycle. That cycle's input beat is discarded.
- Reset beats flush and all traffic. Reset mid-transfer discards every held beat.
- out_data and out_sel_err are stable while out_valid & !out_ready.
- States, implicit in {head_valid, skid_valid}: EMPTY(00), ONE(10), FULL(11). State 01 is unreachable; the bench asserts this.

Optional Feature:
- Macro: MUX_ERR_COUNT_EN.
- Defined: err_count port exists. It increments on every accepted beat with in_sel >= N, including a beat later dropped by flush. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the port and its counter are absent. out_sel_err is still produced.

Decomposition:
- Package mux_pkg holds the constant MUX_ERR_CNT_W = 16 and a typedef for the stored beat struct {data, sel_err}.
- One natural sub-module: skid_buf2. It is a generic 2-entry valid/ready skid buffer over a WIDTH+1 payload with flush.
- mux_pipe_stage = combinational N-way select and error decode, feeding skid_buf2, plus the optional counter.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, out_data=0 on the first cycle after reset drops.
- N=3, out_ready=1: inputs 0x11/0x22/0x33, sel=2, one beat. Expect out_data=0x33, out_valid=1 exactly 1 cycle later, out_sel_err=0.
- Backpressure: out_ready=0, push sel=0,1,0 on consecutive cycles. Only two are accepted; in_ready=0 after the 2nd. With out_ready=1, order is 0x11, 0x22, then the 3rd beat once accepted.
- Illegal select: N=3, sel=3. Expect out_data=0, out_sel_err=1. With MUX_ERR_COUNT_EN, err_count goes 0→1, and saturates at 0xFFFF after 65536+ illegal beats.
- Flush with skid full and in_valid=1 in the same cycle: next cycle out_valid=0, in_ready=1, and the flush-cycle beat never appears.
- Streaming: 1000 random beats with random out_ready. A scoreboard checks no loss, no duplication, in-order delivery, stable out_* under stall, and the {0,1} state never occurring.
